if_map_writer: RTL and testbench

Producer-side companion to the IFmap read address generator in the convolution datapath. It accepts a stream of input-feature-map elements over a valid/ready handshake and writes them row by row into a circular IFmap scratchpad. It tracks buffer occupancy and counts completed rows. It publishes the head address of the oldest resident row, so the reader can load its head register and, once finished with a row, release it back for overwriting.

---
 rtl/if_map_writer.sv | 108 ++++++++++
 tb/tb_if_map_writer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_map_writer.sv
// IFmap producer: streams elements into a circular scratchpad row by row and
// publishes row occupancy plus the oldest row's head address to the reader.
module if_map_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 5,
  parameter int ROWS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  row_len,
  input  logic [ROWS_WIDTH-1:0] num_rows,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_release,
  output logic [ADDR_WIDTH-1:0] rd_head,
  output logic [ADDR_WIDTH:0]   rows_avail,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                state, state_next;
  logic [LEN_WIDTH-1:0]  row_len_q, col;
  logic [ROWS_WIDTH-1:0] num_rows_q, row;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH:0]   occ, occ_next, row_len_occ;
  logic                  start_ok, accept, row_end, last_row, release_ok;

  assign start_ok    = start && (state != FILL) && (row_len != '0) &&
                       (32'(row_len) <= 32'(DEPTH)) && (num_rows != '0);
  assign in_ready    = (state == FILL) && (occ < DEPTH);
  assign accept      = in_valid && in_ready;
  assign row_end     = accept && (col == row_len_q - LEN_WIDTH'(1));
  assign last_row    = (row == num_rows_q - ROWS_WIDTH'(1));
  assign release_ok  = rd_release && (rows_avail != '0);
  assign row_len_occ = (ADDR_WIDTH+1)'(row_len_q);
  assign busy        = (state == FILL);
  assign done        = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start_ok) state_next = FILL;
      FILL:       if (row_end && last_row) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // A release retires a whole row of the latched length; an accept adds one element.
  always_comb begin
    occ_next = occ;
    if (accept)     occ_next = occ_next + (ADDR_WIDTH+1)'(1);
    if (release_ok) occ_next = occ_next - row_len_occ;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen        <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      wptr       <= '0;
      occ        <= '0;
      rd_head    <= '0;
      rows_avail <= '0;
      row_len_q  <= '0;
      num_rows_q <= '0;
      col        <= '0;
      row        <= '0;
    end else begin
      wen <= accept;
      occ <= occ_next;
      if (accept) begin
        waddr <= wptr;
        wdata <= in_data;
        wptr  <= wptr + ADDR_WIDTH'(1);
      end
      if (start_ok) begin
        row_len_q  <= row_len;
        num_rows_q <= num_rows;
        col        <= '0;
        row        <= '0;
      end else if (row_end) begin
        col <= '0;
        row <= row + ROWS_WIDTH'(1);
      end else if (accept) begin
        col <= col + LEN_WIDTH'(1);
      end
      if (release_ok) rd_head <= rd_head + ADDR_WIDTH'(row_len_q);
      if (row_end && !release_ok)      rows_avail <= rows_avail + (ADDR_WIDTH+1)'(1);
      else if (!row_end && release_ok) rows_avail <= rows_avail - (ADDR_WIDTH+1)'(1);
    end
  end

endmodule

// File: tb/tb_if_map_writer.sv
// Directed bench for if_map_writer: an element-count model predicts every
// output each cycle, and directed literals pin the model on key scenarios.
module tb_if_map_writer;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int LW = 5;
  localparam int RW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] row_len = '0;
  logic [RW-1:0] num_rows = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          rd_release = 1'b0;
  logic          in_ready, wen, busy, done;
  logic [AW-1:0] waddr, rd_head;
  logic [DW-1:0] wdata;
  logic [AW:0]   rows_avail;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: everything is derived from running totals of elements and rows.
  int m_total_acc = 0, m_total_rel = 0, m_rows_done = 0, m_rows_rel = 0;
  int m_fill_acc = 0, m_row_len = 0, m_num_rows = 0;
  int m_waddr = 0, m_wdata = 0;
  bit m_active = 0, m_fin = 0, m_wen = 0;
  bit m_acc, m_rel, m_was_active;

  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];
  int bub_exp[4] = '{1, 4, 5, 10};

  if_map_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .ROWS_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len), .num_rows(num_rows),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .wen(wen),
    .waddr(waddr), .wdata(wdata), .rd_release(rd_release), .rd_head(rd_head),
    .rows_avail(rows_avail), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_total_acc = 0; m_total_rel = 0; m_rows_done = 0; m_rows_rel = 0;
      m_fill_acc = 0; m_row_len = 0; m_num_rows = 0;
      m_waddr = 0; m_wdata = 0; m_active = 0; m_fin = 0; m_wen = 0;
    end else begin
      m_was_active = m_active;
      m_acc = in_valid && m_active && ((m_total_acc - m_total_rel) < DEPTH);
      m_rel = rd_release && ((m_rows_done - m_rows_rel) != 0);
      m_wen = m_acc;
      if (m_acc) begin
        m_waddr = m_total_acc % DEPTH;
        m_wdata = int'(in_data);
      end
      if (m_rel) begin
        m_total_rel += m_row_len;
        m_rows_rel++;
      end
      if (m_acc) begin
        m_total_acc++;
        m_fill_acc++;
        if (m_fill_acc % m_row_len == 0) m_rows_done++;
        if (m_fill_acc == m_row_len * m_num_rows) begin
          m_active = 0;
          m_fin = 1;
        end
      end
      if (start && !m_was_active && row_len >= 1 && int'(row_len) <= DEPTH && num_rows != 0) begin
        m_row_len = int'(row_len);
        m_num_rows = int'(num_rows);
        m_fill_acc = 0;
        m_active = 1;
        m_fin = 0;
      end
    end
  end

  always @(negedge clk) begin
    check_output("in_ready", in_ready, int'(m_active && ((m_total_acc - m_total_rel) < DEPTH)));
    check_output("wen", wen, int'(m_wen));
    check_output("waddr", waddr, m_waddr);
    check_output("wdata", wdata, m_wdata);
    check_output("rd_head", rd_head, m_total_rel % DEPTH);
    check_output("rows_avail", rows_avail, m_rows_done - m_rows_rel);
    check_output("busy", busy, int'(m_active));
    check_output("done", done, int'(m_fin));
    if (wen) begin
      wq_addr.push_back(int'(waddr));
      wq_data.push_back(int'(wdata));
      wq_cyc.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  task automatic apply_stimulus(input int len, input int rows);
    start = 1'b1;
    row_len = LW'(len);
    num_rows = RW'(rows);
    step(1);
    start = 1'b0;
  endtask

  task automatic clear_writes();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic check_writes(input string name, input int n, input int addr0, input int data0);
    check_output({name, "_count"}, wq_addr.size(), n);
    for (int k = 0; k < n && k < wq_addr.size(); k++) begin
      check_output({name, "_addr"}, wq_addr[k], (addr0 + k) % DEPTH);
      check_output({name, "_data"}, wq_data[k], data0 + k);
    end
  endtask

  initial begin
    int accepted;
    step(2);
    check_output("rst_in_ready", in_ready, 0);
    check_output("rst_wen", wen, 0);
    check_output("rst_rows_avail", rows_avail, 0);
    check_output("rst_busy", busy, 0);
    rst = 1'b1;
    step(1);

    // Basic 4x3 fill
    clear_writes();
    apply_stimulus(4, 3);
    check_output("basic_busy", busy, 1);
    in_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      in_data = DW'(i);
      step(1);
      if (i == 4) check_output("basic_rows_after4", rows_avail, 1);
      if (i == 8) check_output("basic_rows_after8", rows_avail, 2);
    end
    in_valid = 1'b0;
    check_output("basic_done", done, 1);
    check_output("basic_rows_after12", rows_avail, 3);
    step(1);
    check_writes("basic", 12, 0, 1);
    check_output("basic_rd_head", rd_head, 0);

    // Backpressure and wrap, then a release coincident with a row-completing accept
    do_reset();
    apply_stimulus(8, 4);
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = DW'(100 + i);
      step(1);
    end
    check_output("bp_in_ready_full", in_ready, 0);
    check_output("bp_rows_avail", rows_avail, 2);
    in_data = DW'(999);
    step(2);
    check_output("bp_wen_stalled", wen, 0);
    rd_release = 1'b1;
    step(1);
    rd_release = 1'b0;
    check_output("bp_in_ready_after_rel", in_ready, 1);
    check_output("bp_rd_head", rd_head, 8);
    check_output("bp_rows_after_rel", rows_avail, 1);
    clear_writes();
    for (int i = 0; i < 8; i++) begin
      in_data = DW'(300 + i);
      step(1);
    end
    in_valid = 1'b0;
    step(1);
    check_writes("wrap", 8, 0, 300);

    rd_release = 1'b1;
    step(1);
    rd_release = 1'b0;
    check_output("sim_rd_head_pre", rd_head, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = DW'(400 + i);
      rd_release = (i == 7);
      step(1);
    end
    rd_release = 1'b0;
    in_valid = 1'b0;
    check_output("sim_rows_avail", rows_avail, 1);
    check_output("sim_rd_head", rd_head, 8);
    check_output("sim_done", done, 1);
    apply_stimulus(16, 1);
    in_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      in_data = DW'(500 + i);
      if (in_ready) accepted++;
      step(1);
    end
    in_valid = 1'b0;
    check_output("sim_free_space", accepted, 8);

    // Illegal controls
    do_reset();
    apply_stimulus(0, 3);
    check_output("ill_len0_busy", busy, 0);
    apply_stimulus(17, 3);
    check_output("ill_len17_busy", busy, 0);
    apply_stimulus(4, 0);
    check_output("ill_rows0_busy", busy, 0);
    rd_release = 1'b1;
    step(1);
    rd_release = 1'b0;
    check_output("ill_rel_rows", rows_avail, 0);
    check_output("ill_rel_head", rd_head, 0);
    apply_stimulus(4, 3);
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = DW'(i + 1);
      start = (i == 2);
      row_len = (i == 2) ? LW'(2) : LW'(4);
      num_rows = (i == 2) ? RW'(1) : RW'(3);
      step(1);
      if (i == 3) check_output("ill_midfill_rows", rows_avail, 1);
    end
    start = 1'b0;
    in_valid = 1'b0;
    check_output("ill_midfill_done", done, 1);
    check_output("ill_midfill_rows_end", rows_avail, 3);

    // Asynchronous reset mid-fill
    do_reset();
    apply_stimulus(4, 3);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = DW'(60 + i);
      step(1);
    end
    rst = 1'b0;
    #2;
    check_output("arst_wen", wen, 0);
    check_output("arst_waddr", waddr, 0);
    check_output("arst_wdata", wdata, 0);
    check_output("arst_rows_avail", rows_avail, 0);
    check_output("arst_in_ready", in_ready, 0);
    check_output("arst_busy", busy, 0);
    check_output("arst_done", done, 0);
    check_output("arst_rd_head", rd_head, 0);
    in_valid = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    clear_writes();
    apply_stimulus(4, 3);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = DW'(70 + i);
      step(1);
    end
    in_valid = 1'b0;
    step(1);
    check_writes("arst_refill", 4, 0, 70);

    // Bubbles: valid on cycles 0, 3, 4, 9
    do_reset();
    apply_stimulus(16, 1);
    clear_writes();
    begin
      int base;
      base = cyc;
      for (int c = 0; c <= 10; c++) begin
        in_valid = (c == 0 || c == 3 || c == 4 || c == 9);
        in_data = DW'(50 + c);
        step(1);
      end
      in_valid = 1'b0;
      check_output("bub_count", wq_cyc.size(), 4);
      for (int k = 0; k < 4 && k < wq_cyc.size(); k++) begin
        check_output("bub_cycle", wq_cyc[k] - base, bub_exp[k]);
        check_output("bub_addr", wq_addr[k], k);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
